// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO
module mmio_uart_tx #(
    parameter logic [9:0] BASE_ADDR    = 10'h3F0,
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CNW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [2:0]     r_bit, w_bit;
    logic [7:0]     r_shift, w_shift;
    logic           r_tx, w_tx;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wp, r_rp;
    logic [CNW-1:0] r_count;
    logic           r_ovf;

    logic w_sel_data, w_sel_stat, w_push, w_pop, w_full, w_empty, w_accept, w_tick, w_busy;
    logic w_unused;

    assign w_sel_data = address == BASE_ADDR;
    assign w_sel_stat = address == BASE_ADDR + 10'd1;
    assign hit        = w_sel_data | w_sel_stat;
    assign w_full     = r_count == CNW'(FIFO_DEPTH);
    assign w_empty    = r_count == '0;
    assign w_busy     = r_state != S_IDLE;
    assign w_pop      = !w_busy && !w_empty;
    assign w_push     = MemWrite && w_sel_data;
    assign w_accept   = w_push && (!w_full || w_pop);
    assign w_tick     = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign tx         = r_tx;
    assign w_unused   = ^write_data[31:8];

    // Loads return STATUS or zero from pre-edge state
    always_comb begin
        read_data = '0;
        if (MemRead && w_sel_stat)
            read_data = {23'b0, 5'(r_count), r_ovf, w_empty, w_full, w_busy};
    end

    // FIFO storage; a push only lands when a slot is free or freed this cycle
    always_ff @(posedge CLK) begin
        if (w_accept)
            r_mem[r_wp] <= write_data[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept)
                r_wp <= r_wp + PW'(1);
            if (w_pop)
                r_rp <= r_rp + PW'(1);
            r_count <= r_count + CNW'(w_accept) - CNW'(w_pop);
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (MemWrite && w_sel_stat)
                r_ovf <= 1'b0;
        end
    end

    // Serialiser next state: start bit, 8 data bits LSB first, stop bit
    always_comb begin
        w_next  = r_state;
        w_tx    = r_tx;
        w_cnt   = w_tick ? '0 : r_cnt + CW'(1);
        w_bit   = r_bit;
        w_shift = r_shift;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_tx  = 1'b1;
                if (w_pop) begin
                    w_next  = S_START;
                    w_tx    = 1'b0;
                    w_shift = r_mem[r_rp];
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next  = S_DATA;
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_bit   = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_next = S_STOP;
                        w_tx   = 1'b1;
                    end else begin
                        w_tx    = r_shift[0];
                        w_shift = r_shift >> 1;
                        w_bit   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Serialiser state register; reset aborts any frame and drives the line high
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end
endmodule
